// File: rtl/level_rebuilder.sv
// Rebuilds a level from one-cycle rise/fall request pulses, enforcing a minimum hold
// time between changes and queueing up to DEPTH pending transitions.
// Optional glitch counter: define LEVEL_REBUILDER_GLITCH_CNT_EN.
module level_rebuilder #(
  parameter int unsigned MIN_HOLD = 4,
  parameter int unsigned DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_in_p,
  input  logic       pulse_in_n,
  input  logic       ovf_clr,
  output logic       sig_out,
  output logic       busy,
  output logic       overflow,
  output logic       glitch,
  output logic [7:0] glitch_cnt
);

  localparam int unsigned HOLD_W = 8;
  localparam int unsigned PEND_W = 4;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(DEPTH);

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  logic              r_sig;
  logic              r_busy;
  logic              r_ovf;
  logic              r_glitch;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [PEND_W-1:0] r_pending;

  state_t            w_state;
  logic              w_glitch_ev;
  logic              w_proj;
  logic              w_req_valid;
  logic              w_sig_nxt;
  logic              w_busy_nxt;
  logic              w_ovf_nxt;
  logic              w_drop;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [PEND_W-1:0] w_pend_nxt;

  // Queued transitions always alternate, so the projected level is set by pending parity.
  assign w_state     = (r_hold_cnt != '0) ? ST_HOLD : ST_IDLE;
  assign w_glitch_ev = pulse_in_p & pulse_in_n;
  assign w_proj      = r_sig ^ r_pending[0];
  assign w_req_valid = (pulse_in_p & ~pulse_in_n & ~w_proj) |
                       (pulse_in_n & ~pulse_in_p &  w_proj);

  always_comb begin
    w_sig_nxt  = r_sig;
    w_hold_nxt = r_hold_cnt;
    w_pend_nxt = r_pending;
    w_drop     = 1'b0;
    unique case (w_state)
      ST_IDLE: begin
        if (r_pending != '0) begin
          w_sig_nxt  = ~r_sig;
          w_hold_nxt = HOLD_LOAD;
          if (!w_req_valid) w_pend_nxt = r_pending - PEND_W'(1);
        end else if (w_req_valid) begin
          w_sig_nxt  = ~r_sig;
          w_hold_nxt = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        w_hold_nxt = r_hold_cnt - HOLD_W'(1);
        if (w_req_valid) begin
          if (r_pending == PEND_MAX) w_drop = 1'b1;
          else                       w_pend_nxt = r_pending + PEND_W'(1);
        end
      end
    endcase
    w_ovf_nxt  = (r_ovf & ~ovf_clr) | w_drop;
    w_busy_nxt = (w_hold_nxt != '0) | (w_pend_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig      <= 1'b0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
      r_glitch   <= 1'b0;
      r_hold_cnt <= '0;
      r_pending  <= '0;
    end else begin
      r_sig      <= w_sig_nxt;
      r_busy     <= w_busy_nxt;
      r_ovf      <= w_ovf_nxt;
      r_glitch   <= w_glitch_ev;
      r_hold_cnt <= w_hold_nxt;
      r_pending  <= w_pend_nxt;
    end
  end

  assign sig_out  = r_sig;
  assign busy     = r_busy;
  assign overflow = r_ovf;
  assign glitch   = r_glitch;

`ifdef LEVEL_REBUILDER_GLITCH_CNT_EN
  logic [7:0] r_glitch_cnt;

  // Saturating count of simultaneous p/n requests; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)                                      r_glitch_cnt <= '0;
    else if (w_glitch_ev && (r_glitch_cnt != '1)) r_glitch_cnt <= r_glitch_cnt + 8'(1);
  end

  assign glitch_cnt = r_glitch_cnt;
`else
  assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_level_rebuilder.sv
// Self-checking bench for level_rebuilder: directed scenarios plus random stimulus,
// all compared against a queue-based reference model of the rebuilt level.
module tb_level_rebuilder;

  localparam int MIN_HOLD = 4;
  localparam int DEPTH    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pulse_in_p = 1'b0;
  logic       pulse_in_n = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       sig_out, busy, overflow, glitch;
  logic [7:0] glitch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: level, queue of future levels, cycles since last change.
  bit m_sig, m_busy, m_ovf, m_glitch;
  int m_since = MIN_HOLD;
  int m_cnt   = 0;
  bit m_q[$];

  level_rebuilder #(.MIN_HOLD(MIN_HOLD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pulse_in_p(pulse_in_p), .pulse_in_n(pulse_in_n),
    .ovf_clr(ovf_clr), .sig_out(sig_out), .busy(busy), .overflow(overflow),
    .glitch(glitch), .glitch_cnt(glitch_cnt)
  );

  always #10 clk = ~clk;

  function automatic logic [11:0] dut_v();
    return {sig_out, busy, overflow, glitch, glitch_cnt};
  endfunction

  function automatic logic [11:0] model_v();
    return {m_sig, m_busy, m_ovf, m_glitch, 8'(m_cnt)};
  endfunction

  task automatic model_edge(input bit p, input bit n, input bit clr, input bit r);
    bit proj, valid, drop;
    if (r) begin
      m_sig = 0; m_busy = 0; m_ovf = 0; m_glitch = 0; m_cnt = 0;
      m_since = MIN_HOLD; m_q.delete();
    end else begin
      proj  = (m_q.size() == 0) ? m_sig : m_q[$];
      valid = (p ^ n) && (p != proj);
      drop  = 0;
      m_glitch = p & n;
`ifdef LEVEL_REBUILDER_GLITCH_CNT_EN
      if ((p & n) && m_cnt < 255) m_cnt++;
`endif
      if (m_since >= MIN_HOLD && (m_q.size() != 0 || valid)) begin
        if (m_q.size() != 0) begin
          m_sig = m_q.pop_front();
          if (valid) m_q.push_back(p);
        end else begin
          m_sig = p;
        end
        m_since = 1;
      end else begin
        if (valid) begin
          if (m_q.size() < DEPTH) m_q.push_back(p);
          else                    drop = 1;
        end
        if (m_since < MIN_HOLD) m_since++;
      end
      m_ovf  = (m_ovf && !clr) || drop;
      m_busy = (m_since < MIN_HOLD) || (m_q.size() != 0);
    end
  endtask

  task automatic step(input bit p, input bit n, input bit clr, input bit r);
    pulse_in_p = p; pulse_in_n = n; ovf_clr = clr; rst = r;
    @(posedge clk);
    model_edge(p, n, clr, r);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 1);
    step(1, 1, 1, 1);
    n_checks++;
    if (dut_v() !== 12'h000) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", dut_v(), 12'h000);
    end
  endtask

  task automatic test_single_rise();
    int busy_cycles = 0;
    step(1, 0, 0, 0);
    n_checks++;
    if (sig_out !== 1'b1) begin
      n_fail++; $display("FAIL rise_latency: got sig_out=%b want 1", sig_out);
    end
    if (busy) busy_cycles++;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0);
      if (busy) busy_cycles++;
      n_checks++;
      if (dut_v() !== model_v()) begin
        n_fail++; $display("FAIL single_rise cyc%0d: got %h want %h", i, dut_v(), model_v());
      end
    end
    n_checks++;
    if (busy_cycles != MIN_HOLD - 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rise_busy: got %0d busy cycles (busy=%b) want %0d then 0",
                         busy_cycles, busy, MIN_HOLD - 1);
    end
  endtask

  task automatic test_rise_fall();
    int high_cycles = 0;
    step(1, 1, 0, 1);
    step(1, 0, 0, 0);
    if (sig_out) high_cycles++;
    step(0, 1, 0, 0);
    if (sig_out) high_cycles++;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0);
      if (sig_out) high_cycles++;
      n_checks++;
      if (dut_v() !== model_v()) begin
        n_fail++; $display("FAIL rise_fall cyc%0d: got %h want %h", i, dut_v(), model_v());
      end
    end
    n_checks++;
    if (high_cycles != MIN_HOLD) begin
      n_fail++; $display("FAIL rise_fall_width: got %0d high cycles want %0d", high_cycles, MIN_HOLD);
    end
  endtask

  task automatic test_overflow();
    int  cyc = 0, last_tog = -100, toggles = 0, m_toggles = 0;
    bit  prev, m_prev;
    step(0, 0, 0, 1);
    prev = sig_out; m_prev = m_sig;
    for (int i = 0; i < 40; i++) begin
      if (i < 7) step(i % 2 == 0, i % 2 == 1, 0, 0);
      else       step(0, 0, 0, 0);
      cyc++;
      if (m_sig != m_prev) m_toggles++;
      m_prev = m_sig;
      if (sig_out !== prev) begin
        toggles++;
        n_checks++;
        if (cyc - last_tog < MIN_HOLD) begin
          n_fail++; $display("FAIL hold_spacing: got %0d cycles want >= %0d", cyc - last_tog, MIN_HOLD);
        end
        last_tog = cyc;
      end
      prev = sig_out;
      n_checks++;
      if (dut_v() !== model_v()) begin
        n_fail++; $display("FAIL overflow cyc%0d: got %h want %h", i, dut_v(), model_v());
      end
    end
    n_checks++;
    if (overflow !== 1'b1 || toggles != m_toggles || busy !== 1'b0) begin
      n_fail++; $display("FAIL overflow_end: got ovf=%b toggles=%0d busy=%b want 1 %0d 0",
                         overflow, toggles, busy, m_toggles);
    end
    step(0, 0, 1, 0);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clr: got %b want 0", overflow);
    end
  endtask

  task automatic test_redundant();
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    n_checks++;
    if ({sig_out, busy, overflow} !== 3'b100) begin
      n_fail++; $display("FAIL redundant_rise: got %b want 100", {sig_out, busy, overflow});
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      if (glitch) pulses++;
      step(0, 0, 0, 0);
      if (glitch) pulses++;
      n_checks++;
      if (dut_v() !== model_v()) begin
        n_fail++; $display("FAIL glitch cyc%0d: got %h want %h", i, dut_v(), model_v());
      end
    end
    n_checks++;
`ifdef LEVEL_REBUILDER_GLITCH_CNT_EN
    if (pulses != 3 || sig_out !== 1'b0 || glitch_cnt !== 8'd3) begin
`else
    if (pulses != 3 || sig_out !== 1'b0 || glitch_cnt !== 8'd0) begin
`endif
      n_fail++; $display("FAIL glitch_count: got pulses=%0d sig=%b cnt=%0d", pulses, sig_out, glitch_cnt);
    end
  endtask

  task automatic test_reset_mid_hold();
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(i % 2 == 0, i % 2 == 1, 0, 0);
    n_checks++;
    if (busy !== 1'b1 || m_q.size() != 3) begin
      n_fail++; $display("FAIL pre_reset_busy: got busy=%b want 1", busy);
    end
    step(1, 0, 0, 1);
    n_checks++;
    if ({sig_out, busy} !== 2'b00) begin
      n_fail++; $display("FAIL mid_hold_reset: got %b want 00", {sig_out, busy});
    end
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0);
      n_checks++;
      if (dut_v() !== 12'h000) begin
        n_fail++; $display("FAIL post_reset_quiet cyc%0d: got %h want 000", i, dut_v());
      end
    end
  endtask

  task automatic test_random();
    bit p, n, c, r;
    for (int i = 0; i < 600; i++) begin
      p = ($urandom_range(0, 99) < 30);
      n = ($urandom_range(0, 99) < 30);
      c = ($urandom_range(0, 99) < 5);
      r = ($urandom_range(0, 199) == 0);
      step(p, n, c, r);
      n_checks++;
      if (dut_v() !== model_v()) begin
        n_fail++; $display("FAIL random cyc%0d: got %h want %h", i, dut_v(), model_v());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_rise_fall();
    test_overflow();
    test_redundant();
    test_glitch();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
